// File: rtl/tlb_unit.sv
// tlb_unit: fully-associative TLB with round-robin replacement and fault capture.
// Lookup is combinational against the registered entry state. Writes become visible
// to lookups on the following cycle. A miss on a translated access captures the
// first fault VA, together with a PA hint of VA + PA_HINT_OFS.
// Optional feature macro: TLB_PERF_CNT_EN adds the saturating hit_count and
// miss_count outputs.
module tlb_unit #(
    parameter int          ENTRIES     = 4,
    parameter int          PAGE_BITS   = 12,
    parameter logic [31:0] PA_HINT_OFS = 32'h00001000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vm_enable,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_va,
    output logic [31:0] lookup_pa,
    output logic        hit,
    output logic        miss,
    input  logic        wr_en,
    input  logic [31:0] wr_va,
    input  logic [31:0] wr_pa,
    input  logic        flush,
    input  logic        fault_clear,
    output logic        fault_pending,
    output logic [31:0] fault_va,
    output logic [31:0] fault_pa_hint
`ifdef TLB_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int VPN_W = 32 - PAGE_BITS;
    localparam int IDX_W = $clog2(ENTRIES);

    // Entry state: valid bits are control and are reset; vpn/ppn are data and are not.
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [VPN_W-1:0]   vpn_d [ENTRIES];
    logic [VPN_W-1:0]   ppn_q [ENTRIES];
    logic [VPN_W-1:0]   ppn_d [ENTRIES];
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               fault_pending_q, fault_pending_d;
    logic [31:0]        fault_va_q, fault_va_d;
    logic [31:0]        fault_pa_hint_q, fault_pa_hint_d;

    logic [VPN_W-1:0]   lk_vpn;
    logic               lk_match;
    logic [VPN_W-1:0]   lk_ppn;

    logic [VPN_W-1:0]   wr_vpn;
    logic [VPN_W-1:0]   wr_ppn;
    logic               wr_hit;
    logic [IDX_W-1:0]   wr_hit_idx;
    logic               free_any;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_do;
    logic               fault_capture;

    // Only the page-number fields of the write addresses are used.
    logic               unused_lo;
    assign unused_lo = ^{wr_va[PAGE_BITS-1:0], wr_pa[PAGE_BITS-1:0]};

    assign lk_vpn = lookup_va[31:PAGE_BITS];
    assign wr_vpn = wr_va[31:PAGE_BITS];
    assign wr_ppn = wr_pa[31:PAGE_BITS];
    assign wr_do  = wr_en && !flush;

    // Associative search of the lookup VPN. The write policy keeps matches unique.
    always_comb begin
        lk_match = 1'b0;
        lk_ppn   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (vpn_q[i] == lk_vpn)) begin
                lk_match = 1'b1;
                lk_ppn   = ppn_q[i];
            end
        end
    end

    // Lookup outputs: identity in bypass mode, translated or miss otherwise.
    always_comb begin
        hit       = 1'b0;
        miss      = 1'b0;
        lookup_pa = '0;
        if (lookup_valid) begin
            if (!vm_enable) begin
                hit       = 1'b1;
                lookup_pa = lookup_va;
            end else if (lk_match) begin
                hit       = 1'b1;
                lookup_pa = {lk_ppn, lookup_va[PAGE_BITS-1:0]};
            end else begin
                miss      = 1'b1;
            end
        end
    end

    // Write target selection. The descending scan leaves the lowest free index.
    always_comb begin
        wr_hit     = 1'b0;
        wr_hit_idx = '0;
        free_any   = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (vpn_q[i] == wr_vpn)) begin
                wr_hit     = 1'b1;
                wr_hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        if (wr_hit) begin
            wr_idx = wr_hit_idx;
        end else if (free_any) begin
            wr_idx = free_idx;
        end else begin
            wr_idx = rr_ptr_q;
        end
    end

    // Next valid bits and replacement pointer. Flush overrides any same-cycle write.
    always_comb begin
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            valid_d  = '0;
            rr_ptr_d = '0;
        end else if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            if (!wr_hit && !free_any) begin
                rr_ptr_d = rr_ptr_q + IDX_W'(1);
            end
        end
    end

    // Next entry tags and frame numbers.
    always_comb begin
        vpn_d = vpn_q;
        ppn_d = ppn_q;
        if (wr_do) begin
            vpn_d[wr_idx] = wr_vpn;
            ppn_d[wr_idx] = wr_ppn;
        end
    end

    // Fault capture. A same-cycle clear wins, so that miss is not recorded.
    always_comb begin
        fault_capture   = miss && !fault_pending_q && !fault_clear;
        fault_pending_d = fault_pending_q;
        fault_va_d      = fault_va_q;
        fault_pa_hint_d = fault_pa_hint_q;
        if (fault_clear) begin
            fault_pending_d = 1'b0;
        end else if (fault_capture) begin
            fault_pending_d = 1'b1;
        end
        if (fault_capture) begin
            fault_va_d      = lookup_va;
            fault_pa_hint_d = lookup_va + PA_HINT_OFS;
        end
    end

`ifdef TLB_PERF_CNT_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
    endfunction

    // Performance counters count translated lookups only. They are not affected by flush.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (vm_enable && lookup_valid) begin
            if (hit) begin
                hit_count_d = sat_inc(hit_count_q);
            end else begin
                miss_count_d = sat_inc(miss_count_q);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    // Control and fault registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q         <= '0;
            rr_ptr_q        <= '0;
            fault_pending_q <= 1'b0;
            fault_va_q      <= '0;
            fault_pa_hint_q <= '0;
        end else begin
            valid_q         <= valid_d;
            rr_ptr_q        <= rr_ptr_d;
            fault_pending_q <= fault_pending_d;
            fault_va_q      <= fault_va_d;
            fault_pa_hint_q <= fault_pa_hint_d;
        end
    end

    // Entry data registers. They need no reset because valid_q gates every use.
    always_ff @(posedge clk) begin
        vpn_q <= vpn_d;
        ppn_q <= ppn_d;
    end

    assign fault_pending = fault_pending_q;
    assign fault_va      = fault_va_q;
    assign fault_pa_hint = fault_pa_hint_q;

endmodule
